// File: rtl/fifo_pkg.sv
// Shared definitions for the modport_fifo slice.
// Holds the default data width and depth used by the FIFO top and its
// storage sub-module, and a byte-wide data type for users of the default
// configuration.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage array for modport_fifo: DEPTH x DATA_W entries with one
// synchronous write port and one registered read port.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-low reset; clears only the read register
//   we     - write enable; wdata stored at waddr on the edge
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; mem[raddr] loaded into rdata on the edge
//   raddr  - read address
//   rdata  - registered read data, holds its value while re is low
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Array contents are deliberately left out of reset so the array can map
    // onto block or distributed RAM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register carries the reset so data_out reads zero after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule : fifo_mem

// File: rtl/modport_fifo.sv
// Synchronous single-clock FIFO on a write/read strobe interface.
// A producer pushes data_in with wr, a consumer pops with rd; the popped
// entry appears on data_out one cycle after the accepting edge.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-low reset; empties the FIFO, data_out=0
//   wr       - write request, accepted when not full
//   rd       - read request, accepted when not empty
//   data_in  - write data, sampled on the accepting edge
//   full     - count == DEPTH
//   empty    - count == 0
//   data_out - registered read data, holds when no read is accepted
module modport_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data_out
);

    localparam int AW = $clog2(DEPTH);
    // Count needs one extra bit to represent the completely full state.
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg,  count_next;
    logic          wr_en, rd_en;

    // Flags decode straight from the registered count, so they always agree
    // with it after every edge.
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

    // Acceptance uses the flags as they stand before the edge: no
    // fall-through on empty and no write-through on full.
    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;

    always_comb begin
        // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
        wr_ptr_next = wr_en ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = rd_en ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Reset outranks a coincident request, so strobes are masked while it
    // is asserted.
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en & reset),
        .waddr (wr_ptr_reg),
        .wdata (data_in),
        .re    (rd_en & reset),
        .raddr (rd_ptr_reg),
        .rdata (data_out)
    );

endmodule : modport_fifo

// File: tb/tb_modport_fifo.sv
// Directed self-checking bench for modport_fifo (default 8 x 8-bit).
module tb_modport_fifo;
    import fifo_pkg::*;

    logic  clk;
    logic  reset;
    logic  wr;
    logic  rd;
    data_t data_in;
    logic  full;
    logic  empty;
    data_t data_out;

    int n_checks = 0;
    int n_fail   = 0;

    modport_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .rd       (rd),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic rst_n, input logic w, input logic r, input data_t d);
        @(negedge clk);
        reset   = rst_n;
        wr      = w;
        rd      = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;

        // Reset held with both strobes high.
        step(1'b0, 1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 1'b1, 8'h55);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'h00);

        // First read after release is an underflow and is ignored.
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("rel_rd_dout", 32'(data_out), 32'h00);
        check("rel_rd_empty", 32'(empty), 32'd1);

        // Fill with 0x01..0x08.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(i));
            check("fill_full", 32'(full), 32'(i == 8));
            check("fill_empty", 32'(empty), 32'd0);
        end
        // Overflow write is dropped.
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        check("ovf_full", 32'(full), 32'd1);

        // Drain: 0x01..0x08 in order; 0xFF must never show up.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            check("drain_dout", 32'(data_out), 32'(i));
            check("drain_empty", 32'(empty), 32'(i == 8));
            check("drain_full", 32'(full), 32'd0);
        end
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("udf_dout", 32'(data_out), 32'h08);
        check("udf_empty", 32'(empty), 32'd1);

        // Simultaneous wr/rd with 3 entries resident.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h11 + i));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'(8'h14 + i));
            check("sim_dout", 32'(data_out), 32'(8'h11 + i));
            check("sim_empty", 32'(empty), 32'd0);
            check("sim_full", 32'(full), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            check("sim_tail", 32'(data_out), 32'(8'h15 + i));
            check("sim_tail_empty", 32'(empty), 32'(i == 2));
        end

        // Both strobes on empty: write only, no fall-through.
        step(1'b1, 1'b1, 1'b1, 8'h21);
        check("se_dout", 32'(data_out), 32'h17);
        check("se_empty", 32'(empty), 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("se_read", 32'(data_out), 32'h21);
        check("se_read_empty", 32'(empty), 32'd1);

        // Both strobes on full: read only, write dropped.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
        check("sf_pre_full", 32'(full), 32'd1);
        step(1'b1, 1'b1, 1'b1, 8'h3F);
        check("sf_dout", 32'(data_out), 32'h30);
        check("sf_full", 32'(full), 32'd0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            check("sf_drain", 32'(data_out), 32'(8'h30 + i));
        end
        check("sf_empty", 32'(empty), 32'd1);

        // Wrap-around: 5 in/out, then a full 8-entry pass.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            check("wr5_dout", 32'(data_out), 32'(8'h40 + i));
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i));
        check("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            check("wrap_dout", 32'(data_out), 32'(8'hA0 + i));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Mid-operation reset discards 4 stored entries.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_full", 32'(full), 32'd0);
        check("mid_dout", 32'(data_out), 32'h00);
        step(1'b1, 1'b1, 1'b0, 8'h60);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("mid_new", 32'(data_out), 32'h60);
        check("mid_new_empty", 32'(empty), 32'd1);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_modport_fifo

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Synchronous single-clock FIFO, 8-bit data, 8 entries by default.
- Buffers bytes between a producer driving wr/data_in and a consumer driving rd.
- Reports full/empty status flags.
- Sits on the standard write/read strobe interface used by the FIFO driver and monitor.

Parameters:
- DATA_W, 8: width of data_in/data_out.
- DEPTH, 8: number of storage entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH): pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- wr  input  1  write request; data_in pushed when accepted.
- rd  input  1  read request; head entry popped to data_out when accepted.
- data_in  input  DATA_W  write data, sampled on the accepting edge.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- data_out  output  DATA_W  registered read data.

Behaviour:
- Reset (reset==0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, data_out=0.
  - Memory contents are not cleared.
  - Reset has priority over wr/rd in the same cycle.
  - Reset mid-operation discards all stored data.
- Acceptance is evaluated from the flags as they stand before the edge:
  - wr_en = wr & ~full.
  - rd_en = rd & ~empty.
- Write: on wr_en, mem[wr_ptr] <= data_in and wr_ptr increments, wrapping from DEPTH-1 to 0.
- Read:
  - On rd_en, data_out <= mem[rd_ptr] and rd_ptr increments with the same wrap.
  - Latency is one cycle: data is valid after the edge that accepted rd.
  - data_out holds its last value when no read is accepted.
- Count update:
  - wr_en only: count+1.
  - rd_en only: count-1.
  - Both: count unchanged.
- Flags are registered, or combinational from registered count; both must equal the count-based definitions after every edge.
- Overflow: wr while full is ignored; no pointer, memory or count change. No error output.
- Underflow: rd while empty is ignored; data_out unchanged.
- Simultaneous wr and rd:
  - Neither full nor empty: both happen; count is constant and full/empty are unchanged.
  - When empty: only the write is accepted (no fall-through); empty drops next cycle.
  - When full: only the read is accepted; the write is dropped and full drops next cycle.
- Ordering is strict FIFO across pointer wrap-around.
- X on wr/rd while reset is high is not supported.

Decomposition:
- Package fifo_pkg holds:
  - localparams DATA_W_DEF=8 and DEPTH_DEF=8.
  - typedef data_t (logic [DATA_W_DEF-1:0]).
- Sub-module fifo_mem (natural split):
  - DEPTH x DATA_W register array.
  - Synchronous write port (we, waddr, wdata).
  - Registered read port (re, raddr, rdata).
- The top level contains pointers, count, flag logic and the acceptance gating.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr=1, rd=1 -> empty=1, full=0, data_out=0x00; the first read after release is ignored.
- Fill/overflow: write 0x01..0x08 -> full=1 after the 8th edge; a 9th write of 0xFF is ignored and count stays 8.
- Drain/underflow: 8 reads -> data_out 0x01..0x08 in order, each one cycle after its rd. empty=1 after the last. A further rd leaves data_out=0x08.
- Simultaneous:
  - With 3 entries, assert wr=1/rd=1 for 4 cycles -> count stays 3, data_out returns the oldest entries in order.
  - On empty with both -> only the write lands, empty=0.
  - On full with both -> only the read lands, full=0.
- Wrap-around: 5 writes, 5 reads, then 8 writes (0xA0..0xA7) -> full=1; 8 reads return 0xA0..0xA7 in order.
- Mid-operation reset: with 4 entries, pulse reset=0 for one cycle -> empty=1, count 0; the next write/read pair returns the new data, not the old.
